// File: rtl/dmux_nway_stream_pkg.sv
// Shared definitions for the N-way stream demultiplexer: Hack word width,
// a constant-foldable clog2 for sizing the select, and the slot state encoding.
package dmux_nway_stream_pkg;

  localparam int HACK_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Ceiling log2 with a floor of 1 so a select port is never zero bits wide.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((2 ** result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dmux_nway_stream_slot.sv
// One-entry output slot: holds a single beat for one channel until its sink
// takes it. A load in the same cycle as a drain replaces the beat with no bubble.
import dmux_nway_stream_pkg::*;

module dmux_nway_stream_slot #(
  parameter int WIDTH = HACK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Next-state: a load always wins (fill or drain-and-reload); a drain alone empties.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = load_data;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot register; reset discards any held beat and clears the payload.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid = (state_q == SLOT_FULL);
  assign data  = data_q;

endmodule

// File: rtl/dmux_nway_stream.sv
// Registered, flow-controlled N-way demultiplexer. Each channel has its own
// one-entry slot, so a stalled sink only back-pressures beats addressed to it.
// Beats addressed past the last channel are accepted, dropped and flagged.
import dmux_nway_stream_pkg::*;

module dmux_nway_stream #(
  parameter int WIDTH  = HACK_W,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    drop_err
);

  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W + 1)'(NUM_CH);

  logic [NUM_CH-1:0] slot_vld;
  logic [NUM_CH-1:0] load;
  logic              sel_ok;
  logic              ch_busy;
  logic              accept;
  logic              drop_err_q, drop_err_d;

  assign sel_ok = ({1'b0, in_sel} < NUM_CH_L);

  // Channel decode and ready: the addressed slot can take a beat if it is empty
  // or being drained this cycle; an out-of-range select is always accepted.
  always_comb begin
    ch_busy = 1'b0;
    load    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (in_sel == SEL_W'(k)) begin
        ch_busy = slot_vld[k] & ~out_ready[k];
      end
    end
    in_ready = rst_n & ~ch_busy;
    accept   = in_valid & in_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      load[k] = accept & (in_sel == SEL_W'(k));
    end
    drop_err_d = accept & ~sel_ok;
  end

  // Drop flag: one cycle high for every discarded out-of-range beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_err_q <= 1'b0;
    end else begin
      drop_err_q <= drop_err_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    dmux_nway_stream_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[k]),
      .drain    (out_ready[k]),
      .load_data(in_data),
      .valid    (slot_vld[k]),
      .data     (out_data[k*WIDTH +: WIDTH])
    );
  end

  assign out_valid = slot_vld;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_dmux_nway_stream.sv
module tb_dmux_nway_stream;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = '0;
  logic [63:0] out_data;
  logic        drop_err;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [15:0] b_in_data = '0;
  logic [1:0]  b_in_sel = '0;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready = '0;
  logic [47:0] b_out_data;
  logic        b_drop_err;

  int checks = 0;
  int failures = 0;

  beat_t      sb[$];
  logic [3:0] mvalid = '0;

  always #5 clk = ~clk;

  dmux_nway_stream #(.WIDTH(16), .NUM_CH(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .drop_err(drop_err)
  );

  dmux_nway_stream #(.WIDTH(16), .NUM_CH(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .drop_err(b_drop_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int front_idx(input int k);
    for (int i = 0; i < sb.size(); i++) begin
      if (int'(sb[i].ch) == k) return i;
    end
    return -1;
  endfunction

  // One clock of stimulus on the 4-channel DUT, checked against the reference model.
  task automatic step(input logic v, input logic [1:0] s, input logic [15:0] d,
                      input logic [3:0] ordy, input logic rn);
    logic exp_rdy;
    int   idx;
    @(negedge clk);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = ordy;
    rst_n     = rn;
    #1;
    exp_rdy = rn & (~mvalid[s] | ordy[s]);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(mvalid));
    chk("drop_err", 64'(drop_err), 64'd0);
    for (int k = 0; k < 4; k++) begin
      if (mvalid[k]) begin
        idx = front_idx(k);
        if (idx < 0) chk("sb_entry", 64'd0, 64'd1);
        else chk($sformatf("out_data%0d", k), 64'(out_data[k*16 +: 16]), 64'(sb[idx].d));
      end
    end
    @(posedge clk);
    if (!rn) begin
      mvalid = '0;
      sb.delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (mvalid[k] && ordy[k]) begin
          idx = front_idx(k);
          if (idx >= 0) sb.delete(idx);
          mvalid[k] = 1'b0;
        end
      end
      if (v && exp_rdy) begin
        sb.push_back('{ch: s, d: d});
        mvalid[s] = 1'b1;
      end
    end
  endtask

  initial begin
    // Reset held with a beat offered.
    step(1'b1, 2'd0, 16'h5555, 4'h0, 1'b0);
    step(1'b1, 2'd0, 16'h5555, 4'h0, 1'b0);
    @(negedge clk); #1;
    chk("rst_out_data", out_data, 64'd0);

    // Walk selects with all sinks ready.
    for (int s = 0; s < 4; s++) step(1'b1, 2'(s), 16'hA000 + 16'(s), 4'hF, 1'b1);
    step(1'b0, 2'd0, 16'h0, 4'hF, 1'b1);

    // ch2 stalled: second beat back-pressured, then delivered without a bubble.
    step(1'b1, 2'd2, 16'h1111, 4'b1011, 1'b1);
    step(1'b1, 2'd2, 16'h2222, 4'b1011, 1'b1);
    step(1'b1, 2'd2, 16'h2222, 4'b1011, 1'b1);
    step(1'b1, 2'd2, 16'h2222, 4'b1111, 1'b1);
    step(1'b0, 2'd0, 16'h0, 4'b1111, 1'b1);
    step(1'b0, 2'd0, 16'h0, 4'b1111, 1'b1);

    // ch1 stalled and full; ch3 still accepts.
    step(1'b1, 2'd1, 16'hBEEF, 4'b1101, 1'b1);
    step(1'b1, 2'd3, 16'hC0DE, 4'b0101, 1'b1);
    step(1'b1, 2'd1, 16'h7777, 4'b0101, 1'b1);
    step(1'b0, 2'd0, 16'h0, 4'b1111, 1'b1);
    step(1'b0, 2'd0, 16'h0, 4'b1111, 1'b1);

    // Reset mid-stream with ch0 full.
    step(1'b1, 2'd0, 16'h0BAD, 4'b0000, 1'b1);
    step(1'b0, 2'd0, 16'h0, 4'b0000, 1'b0);
    step(1'b0, 2'd0, 16'h0, 4'b0000, 1'b1);
    step(1'b0, 2'd0, 16'h0, 4'b1111, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
           4'($urandom_range(0, 15)), 1'b1);
    end
    step(1'b0, 2'd0, 16'h0, 4'hF, 1'b1);

    // Three-channel instance: out-of-range select is dropped and flagged.
    @(negedge clk);
    b_in_valid = 1'b1; b_in_sel = 2'd0; b_in_data = 16'h1234; b_out_ready = 3'b000;
    #1 chk("b_rdy_ch0", 64'(b_in_ready), 64'd1);
    @(negedge clk);
    b_in_sel = 2'd3; b_in_data = 16'hDEAD;
    #1 chk("b_rdy_inv", 64'(b_in_ready), 64'd1);
    chk("b_drop_idle", 64'(b_drop_err), 64'd0);
    chk("b_vld_ch0", 64'(b_out_valid), 64'b001);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1 chk("b_drop_pulse", 64'(b_drop_err), 64'd1);
    chk("b_vld_keep", 64'(b_out_valid), 64'b001);
    chk("b_data_keep", 64'(b_out_data[15:0]), 64'h1234);
    @(negedge clk); #1;
    chk("b_drop_end", 64'(b_drop_err), 64'd0);
    @(negedge clk);
    b_in_valid = 1'b1; b_in_sel = 2'd3;
    @(negedge clk);
    #1 chk("b_drop_b2b1", 64'(b_drop_err), 64'd1);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1 chk("b_drop_b2b2", 64'(b_drop_err), 64'd1);
    @(negedge clk); #1;
    chk("b_drop_b2b_end", 64'(b_drop_err), 64'd0);
    chk("b_vld_final", 64'(b_out_valid), 64'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
